alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational ALU
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  input  logic             r1_valid,
  output logic             r0_ready,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [2:0]       r0_op,
  input  logic [2:0]       r1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  input  logic             rsp_ready,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic             id_q, id_d, zero_q, zero_d, err_q, err_d;
  logic [15:0]      cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             gnt0, gnt1, illegal;
  // grant only in IDLE and out of reset; pointer breaks ties when both are valid
  always_comb begin
    gnt0 = rst_n && state_q == IDLE && r0_valid && (!r1_valid || !ptr_q);
    gnt1 = rst_n && state_q == IDLE && r1_valid && (!r0_valid || ptr_q);
    illegal = op_q == 3'b011 || op_q == 3'b111;
  end
  // next-state: latch operands on accept, capture ALU output in EXEC, hold in RESP
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      IDLE: if (gnt0 || gnt1) begin
        state_d = EXEC;
        ptr_d   = gnt0;
        a_d     = gnt1 ? r1_a : r0_a;
        b_d     = gnt1 ? r1_b : r0_b;
        op_d    = gnt1 ? r1_op : r0_op;
        id_d    = gnt1;
        cnt0_d  = cnt0_q + 16'(gnt0);
        cnt1_d  = cnt1_q + 16'(gnt1);
      end
      EXEC: begin
        state_d = RESP;
        res_d   = illegal ? '0 : alu_result;
        zero_d  = !illegal && alu_zero;
        err_d   = illegal;
      end
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous active-low reset clearing everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end
  assign r0_ready    = gnt0;
  assign r1_ready    = gnt1;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
  assign rsp_valid   = state_q == RESP;
  assign rsp_id      = id_q;
  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;
  assign rsp_err     = err_q;
  assign gnt_cnt0    = cnt0_q;
  assign gnt_cnt1    = cnt1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized transaction-level check of alu_arbiter against a reference model
module tb_alu_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        r0_valid = 0, r1_valid = 0, r0_ready, r1_ready;
  logic [31:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
  logic [2:0]  r0_op = 0, r1_op = 0, alu_control;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic        alu_zero, rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_ready = 0;
  logic [15:0] gnt_cnt0, gnt_cnt1;
  int          n_checks = 0, n_errors = 0;
  logic        ptr_m = 0;
  int          cnt0_m = 0, cnt1_m = 0;
  logic [31:0] last_res;
  logic        last_zero, last_err, last_id;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b), .r0_op(r0_op), .r1_op(r1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, b, input logic [2:0] op);
    case (op)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a - b;
      3'd2:    alu_f = $signed(a) >>> b[4:0];
      3'd4:    alu_f = a >> b[4:0];
      3'd5:    alu_f = a & b;
      3'd6:    alu_f = a | b;
      default: alu_f = a ^ b ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_control);
  assign alu_zero   = alu_result == 0;

  task automatic check(input string tag, input logic [63:0] got, exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    ptr_m = 0;
    cnt0_m = 0;
    cnt1_m = 0;
  endtask

  task automatic txn(input logic v0, v1, input logic [31:0] a0, b0, input logic [2:0] o0,
                     input logic [31:0] a1, b1, input logic [2:0] o1, input int stall);
    logic id, ee, ez;
    logic [31:0] ea, eb, er;
    logic [2:0] eo;
    r0_valid = v0; r1_valid = v1;
    r0_a = a0; r0_b = b0; r0_op = o0;
    r1_a = a1; r1_b = b1; r1_op = o1;
    rsp_ready = 0;
    #1;
    id = (v0 && v1) ? ptr_m : v1;
    ea = id ? a1 : a0;
    eb = id ? b1 : b0;
    eo = id ? o1 : o0;
    ee = eo == 3'd3 || eo == 3'd7;
    er = ee ? 32'd0 : alu_f(ea, eb, eo);
    ez = !ee && er == 0;
    ptr_m = !id;
    if (id) cnt1_m++; else cnt0_m++;
    check("r0_ready_idle", r0_ready, !id);
    check("r1_ready_idle", r1_ready, id);
    tick;
    r0_a = $urandom; r0_b = $urandom; r0_op = 3'($urandom);
    r1_a = $urandom; r1_b = $urandom; r1_op = 3'($urandom);
    r0_valid = 1; r1_valid = 1;
    #1;
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_control", alu_control, eo);
    check("rsp_valid_exec", rsp_valid, 0);
    check("ready_exec", r0_ready | r1_ready, 0);
    tick;
    for (int i = 0; i <= stall; i++) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_id", rsp_id, id);
      check("rsp_result", rsp_result, er);
      check("rsp_zero", rsp_zero, ez);
      check("rsp_err", rsp_err, ee);
      check("ready_resp", r0_ready | r1_ready, 0);
      if (i < stall) tick;
    end
    last_res = rsp_result; last_zero = rsp_zero; last_err = rsp_err; last_id = rsp_id;
    rsp_ready = 1;
    tick;
    check("rsp_valid_after", rsp_valid, 0);
    check("idle_after", r0_ready | r1_ready, 1);
    check("gnt_cnt0", gnt_cnt0, 16'(cnt0_m));
    check("gnt_cnt1", gnt_cnt1, 16'(cnt1_m));
    r0_valid = 0; r1_valid = 0; rsp_ready = 0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    model_reset();
    tick;
    tick;
    rst_n = 1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    r0_valid = 1; r1_valid = 1; r0_a = 32'h1234; r1_a = 32'h5678;
    do_reset();
    r0_valid = 1; r1_valid = 1;
    rst_n = 0;
    #1;
    check("reset_r0_ready", r0_ready, 0);
    check("reset_r1_ready", r1_ready, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_alu_control", alu_control, 0);
    check("reset_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_err}, 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_cnts", {gnt_cnt0, gnt_cnt1}, 0);
    rst_n = 1; r0_valid = 0; r1_valid = 0;
    txn(1, 0, 2, 3, 0, 0, 0, 0, 0);
    check("add_result", last_res, 5);
    check("add_id", last_id, 0);
    check("add_cnt0", gnt_cnt0, 1);
    txn(0, 1, 0, 0, 0, 5, 12, 1, 0);
    check("sub_result", last_res, 32'hFFFF_FFF9);
    check("sub_id", last_id, 1);
    txn(0, 1, 0, 0, 0, 7, 7, 1, 0);
    check("sub_zero_result", last_res, 0);
    check("sub_zero_flag", last_zero, 1);
    do_reset();
    txn(1, 1, 32'hFFFF_F000, 4, 2, 32'hFFFF_F000, 4, 4, 0);
    check("sra_id", last_id, 0);
    check("sra_result", last_res, 32'hFFFF_FF00);
    txn(1, 1, 32'hFFFF_F000, 4, 2, 32'hFFFF_F000, 4, 4, 3);
    check("srl_id", last_id, 1);
    check("srl_result", last_res, 32'h0FFF_FF00);
    check("both_cnt0", gnt_cnt0, 1);
    check("both_cnt1", gnt_cnt1, 1);
    txn(1, 0, 9, 9, 3, 0, 0, 0, 0);
    check("err011", {last_err, last_zero}, 2'b10);
    check("err011_result", last_res, 0);
    txn(1, 0, 9, 1, 7, 0, 0, 0, 1);
    check("err111", {last_err, last_zero}, 2'b10);
    check("err111_result", last_res, 0);
    r0_valid = 1; r0_a = 1; r0_b = 1; r0_op = 0;
    #1;
    tick;
    rst_n = 0; r0_valid = 0;
    tick;
    model_reset();
    check("rst_exec_rsp_valid", rsp_valid, 0);
    check("rst_exec_cnts", {gnt_cnt0, gnt_cnt1}, 0);
    check("rst_exec_alu_a", alu_a, 0);
    rst_n = 1;
    tick;
    tick;
    check("rst_exec_no_rsp", rsp_valid, 0);
    for (int n = 0; n < 40; n++) begin
      logic v0, v1;
      logic [31:0] a0, b0, a1, b1;
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      txn(v0, v1, a0, b0, 3'($urandom_range(0, 7)), a1, b1, 3'($urandom_range(0, 7)),
          int'($urandom_range(0, 2)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
